pc_fetch_sequencer: RTL and testbench

//   Program-counter register and instruction-fetch sequencer. Consumes the 32-bit next-PC

---
 rtl/pc_fetch_sequencer.sv | 81 ++++++++
 tb/tb_pc_fetch_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program counter and single-outstanding instruction fetch sequencer with a
// one-entry output buffer toward decode; redirects flush and re-steer the PC.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_req_valid,
    input  logic        fetch_req_ready,
    output logic [31:0] fetch_addr,
    input  logic        fetch_rsp_valid,
    input  logic [31:0] fetch_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] WAIT  = 1'b1;

    logic [0:0]  state;
    logic        discard;
    logic [31:0] pc;
    logic        handshake;
    logic        rsp_in_wait;

    // A redirect in the same cycle wins over issuing a request at the stale pc.
    assign fetch_req_valid = rst_n && (state == FETCH) && !instr_valid && !redirect_valid;
    assign fetch_addr      = {pc[31:2], 2'b00};
    assign handshake       = fetch_req_valid && fetch_req_ready;
    assign rsp_in_wait     = (state == WAIT) && fetch_rsp_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            state       <= FETCH;
            discard     <= 1'b0;
            instr_valid <= 1'b0;
            instr_data  <= 32'h0;
            instr_pc    <= 32'h0;
        end else begin
            // The buffer is always empty while in WAIT, so capture never collides with consume.
            if (redirect_valid) begin
                instr_valid <= 1'b0;
            end else if (rsp_in_wait && !discard) begin
                instr_valid <= 1'b1;
                instr_data  <= fetch_rsp_data;
                instr_pc    <= pc;
            end else if (instr_valid && instr_ready) begin
                instr_valid <= 1'b0;
            end

            if (redirect_valid)
                pc <= {redirect_target[31:2], 2'b00};
            else if (rsp_in_wait && !discard)
                pc <= pc + PC_INC;

            case (state)
                FETCH: begin
                    if (handshake)
                        state <= WAIT;
                end
                WAIT: begin
                    if (fetch_rsp_valid) begin
                        state   <= FETCH;
                        discard <= 1'b0;
                    end else if (redirect_valid) begin
                        // The in-flight word belongs to the old path; drop it on arrival.
                        discard <= 1'b1;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboarded bench for pc_fetch_sequencer: directed fetch, stall, redirect,
// reset-in-flight and PC wrap scenarios against a latency-programmable memory.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_req_valid;
    logic        fetch_req_ready;
    logic [31:0] fetch_addr;
    logic        fetch_rsp_valid;
    logic [31:0] fetch_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    // Second instance exercises the 32-bit PC wrap from a high reset vector.
    logic        w_redirect_valid;
    logic [31:0] w_redirect_target;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [31:0] w_fetch_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_instr_valid;
    logic        w_instr_ready;
    logic [31:0] w_instr_data;
    logic [31:0] w_instr_pc;

    int          checks = 0;
    int          failures = 0;
    int          consumed = 0;
    int          w_seen = 0;
    int          lat = 1;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    pc_fetch_sequencer #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
        .fetch_addr(fetch_addr), .fetch_rsp_valid(fetch_rsp_valid),
        .fetch_rsp_data(fetch_rsp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc)
    );

    pc_fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .PC_INC(32'd4)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(w_redirect_valid), .redirect_target(w_redirect_target),
        .fetch_req_valid(w_req_valid), .fetch_req_ready(w_req_ready),
        .fetch_addr(w_fetch_addr), .fetch_rsp_valid(w_rsp_valid),
        .fetch_rsp_data(w_rsp_data), .instr_valid(w_instr_valid),
        .instr_ready(w_instr_ready), .instr_data(w_instr_data), .instr_pc(w_instr_pc)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_to(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out @%0t", name, $time);
    endtask

    task automatic expect_instr(input logic [31:0] pc);
        sb_q.push_back({pc, mem(pc)});
    endtask

    // Memory for the main instance: one request in flight, response lat cycles after accept.
    task automatic memory0();
        int          pend_cnt = 0;
        logic [31:0] pend_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (pend_cnt == 1) begin
                fetch_rsp_valid = 1'b1;
                fetch_rsp_data  = mem(pend_addr);
                pend_cnt = 0;
            end else begin
                fetch_rsp_valid = 1'b0;
                if (pend_cnt > 1) pend_cnt--;
            end
            if (fetch_req_valid && fetch_req_ready) begin
                pend_cnt  = lat;
                pend_addr = fetch_addr;
            end
        end
    endtask

    task automatic memory1();
        logic        pend = 1'b0;
        logic [31:0] addr_q = 32'h0;
        forever begin
            @(negedge clk);
            w_rsp_valid = pend;
            w_rsp_data  = mem(addr_q);
            pend   = w_req_valid && w_req_ready;
            addr_q = w_fetch_addr;
        end
    endtask

    task automatic monitor0();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid && instr_ready) begin
                consumed++;
                if (sb_q.size() == 0) begin
                    fail_to("sb_unexpected_instr");
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_instr_pc", instr_pc, e[63:32]);
                    chk("sb_instr_data", instr_data, e[31:0]);
                end
            end
        end
    endtask

    task automatic monitor1();
        forever begin
            @(negedge clk);
            if (rst_n && w_instr_valid && w_instr_ready) begin
                w_seen++;
                if (w_seen == 1) begin
                    chk("wrap_first_pc", w_instr_pc, 32'hFFFF_FFFC);
                    chk("wrap_first_data", w_instr_data, mem(32'hFFFF_FFFC));
                end else if (w_seen == 2) begin
                    chk("wrap_second_pc", w_instr_pc, 32'h0000_0000);
                    chk("wrap_second_data", w_instr_data, mem(32'h0000_0000));
                end
            end
        end
    endtask

    task automatic wait_consumed(input int target);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (consumed >= target) break;
        end
        if (consumed < target) fail_to("wait_consumed");
        #1;
    endtask

    task automatic wait_hs();
        logic ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fetch_req_valid && fetch_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_to("wait_handshake");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        fetch_req_ready = 1'b1;
        fetch_rsp_valid = 1'b0;
        fetch_rsp_data = 32'h0;
        instr_ready = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_target = 32'h0;
        w_req_ready = 1'b1;
        w_rsp_valid = 1'b0;
        w_rsp_data = 32'h0;
        w_instr_ready = 1'b1;
        fork
            memory0();
            memory1();
            monitor0();
            monitor1();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_req_valid", {31'h0, fetch_req_valid}, 32'h0);
        chk("rst_fetch_addr", fetch_addr, 32'h0);
        chk("rst_instr_data", instr_data, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);

        // Straight-line fetch with 1-cycle memory
        expect_instr(32'h0);
        expect_instr(32'h4);
        expect_instr(32'h8);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_consumed(3);
        fetch_req_ready = 1'b0;

        // Decode stall with a full buffer
        instr_ready = 1'b0;
        fetch_req_ready = 1'b1;
        expect_instr(32'hC);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid) begin ok = 1'b1; break; end
        end
        if (!ok) fail_to("stall_fill");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_req_valid", {31'h0, fetch_req_valid}, 32'h0);
            chk("stall_instr_pc", instr_pc, 32'hC);
            chk("stall_instr_data", instr_data, mem(32'hC));
        end
        @(posedge clk); #1;
        expect_instr(32'h10);
        instr_ready = 1'b1;
        wait_consumed(5);
        fetch_req_ready = 1'b0;

        // Redirect while waiting; the in-flight word must be dropped
        lat = 3;
        fetch_req_ready = 1'b1;
        expect_instr(32'h1000);
        wait_hs();
        lat = 1;
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_1003;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fetch_req_valid) begin ok = 1'b1; break; end
        end
        if (!ok) fail_to("redir_wait_refetch");
        chk("redir_wait_fetch_addr", fetch_addr, 32'h0000_1000);
        wait_consumed(6);
        fetch_req_ready = 1'b0;

        // Redirect coincident with the response
        lat = 2;
        fetch_req_ready = 1'b1;
        expect_instr(32'h2000);
        wait_hs();
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_2000;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        chk("redir_rsp_req_valid", {31'h0, fetch_req_valid}, 32'h1);
        chk("redir_rsp_fetch_addr", fetch_addr, 32'h0000_2000);
        wait_consumed(7);
        fetch_req_ready = 1'b0;

        // Reset pulse mid-wait; the late response must be ignored
        lat = 3;
        fetch_req_ready = 1'b1;
        wait_hs();
        fetch_req_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_wait_instr_valid", {31'h0, instr_valid}, 32'h0);
            chk("rst_wait_fetch_addr", fetch_addr, 32'h0);
        end
        @(posedge clk); #1;
        lat = 1;
        expect_instr(32'h0);
        fetch_req_ready = 1'b1;
        wait_consumed(8);
        fetch_req_ready = 1'b0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'h0);
        chk("wrap_two_seen", {31'h0, w_seen >= 2}, 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
